// File: rtl/key_event.sv
// Key event decoder: press/release edges, long-press and auto-repeat on a debounced key.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat pulses while held past the long-press point).
// release and repeat are SystemVerilog keywords, so those ports are named key_release / key_repeat.
//
// state | meaning
// IDLE  | key released, waiting for a rising edge
// HOLD  | key held, counting toward the long-press threshold
// LONG  | long-press declared, counting auto-repeat periods
module key_event #(
  parameter int LONG_CYC   = 1000,
  parameter int REPEAT_CYC = 200,
  parameter int TMR_BW     = 16
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       reset,
  input  logic       key,
  output logic       press,
  output logic       key_release,
  output logic       long_press,
  output logic       key_repeat,
  output logic       held,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    LONG = 2'd2
  } state_t;

  localparam logic [TMR_BW-1:0] LONG_TC   = TMR_BW'(LONG_CYC - 1);
  localparam logic [TMR_BW-1:0] REPEAT_TC = TMR_BW'(REPEAT_CYC - 1);
  localparam logic [TMR_BW-1:0] TMR_ONE   = TMR_BW'(1);

  // Thresholds must fit the timer and leave at least one count before terminal.
  generate
    if (LONG_CYC < 2 || LONG_CYC > (2**TMR_BW) - 1 ||
        REPEAT_CYC < 2 || REPEAT_CYC > (2**TMR_BW) - 1) begin : g_bad_cfg
      $error("key_event: LONG_CYC/REPEAT_CYC out of range for TMR_BW");
    end
  endgenerate

  state_t            state;
  state_t            state_nx;
  logic              key_d;
  logic              rise;
  logic              fall;
  logic [TMR_BW-1:0] timer;
  logic [TMR_BW-1:0] timer_nx;
  logic              long_hit;
  logic              rpt_hit;
  logic              press_nx;
  logic              release_nx;
  logic              long_nx;
  logic              repeat_nx;

  assign rise     = key & ~key_d;
  assign fall     = ~key & key_d;
  assign long_hit = (timer == LONG_TC);
  assign rpt_hit  = (timer == REPEAT_TC);

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      key_d <= 1'b0;
    end else if (reset) begin
      key_d <= 1'b0;
    end else begin
      key_d <= key;
    end
  end

  // State register and timer
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state <= IDLE;
      timer <= '0;
    end else if (reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
    end
  end

  // Next-state and timer update
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    case (state)
      IDLE: begin
        timer_nx = '0;
        if (rise) begin
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (fall) begin
          state_nx = IDLE;
          timer_nx = '0;
        end else if (long_hit) begin
          state_nx = LONG;
          timer_nx = '0;
        end else begin
          timer_nx = timer + TMR_ONE;
        end
      end
      LONG: begin
        if (fall) begin
          state_nx = IDLE;
          timer_nx = '0;
        end else begin
`ifdef KEY_REPEAT_EN
          timer_nx = rpt_hit ? '0 : (timer + TMR_ONE);
`else
          // Without auto-repeat the timer parks until the key is released.
          timer_nx = timer;
`endif
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end

  // Output decode; a fall always wins over the long/repeat thresholds.
  always_comb begin
    press_nx   = 1'b0;
    release_nx = 1'b0;
    long_nx    = 1'b0;
    repeat_nx  = 1'b0;
    case (state)
      IDLE: press_nx = rise;
      HOLD: begin
        release_nx = fall;
        long_nx    = ~fall & long_hit;
      end
      LONG: begin
        release_nx = fall;
`ifdef KEY_REPEAT_EN
        repeat_nx  = ~fall & rpt_hit;
`else
        repeat_nx  = 1'b0 & rpt_hit;
`endif
      end
      default: begin
        press_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      press       <= 1'b0;
      key_release <= 1'b0;
      long_press  <= 1'b0;
      key_repeat  <= 1'b0;
      held        <= 1'b0;
      press_cnt   <= 8'd0;
    end else if (reset) begin
      press       <= 1'b0;
      key_release <= 1'b0;
      long_press  <= 1'b0;
      key_repeat  <= 1'b0;
      held        <= 1'b0;
      press_cnt   <= 8'd0;
    end else begin
      press       <= press_nx;
      key_release <= release_nx;
      long_press  <= long_nx;
      key_repeat  <= repeat_nx;
      held        <= (state_nx != IDLE);
      if (press_nx && (press_cnt != 8'hFF)) begin
        press_cnt <= press_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: table-driven key pulses checked cycle by cycle against a queue of expected outputs.
// Expectations follow the KEY_REPEAT_EN build setting.
module tb_key_event;

  localparam int LC = 10;
  localparam int RC = 4;
`ifdef KEY_REPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  logic       clk;
  logic       aclr;
  logic       reset;
  logic       key;
  logic       press;
  logic       key_release;
  logic       long_press;
  logic       key_repeat;
  logic       held;
  logic [7:0] press_cnt;

  key_event #(.LONG_CYC(LC), .REPEAT_CYC(RC), .TMR_BW(16)) dut (
    .clk         (clk),
    .aclr        (aclr),
    .reset       (reset),
    .key         (key),
    .press       (press),
    .key_release (key_release),
    .long_press  (long_press),
    .key_repeat  (key_repeat),
    .held        (held),
    .press_cnt   (press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       prs;
    logic       rel;
    logic       lng;
    logic       rpt;
    logic       hld;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    int hi;
    int lo;
    int n_long;
    int n_rpt_en;
    int n_rpt_dis;
    int cnt_after;
  } vec_t;

  exp_t sb[$];
  vec_t vt[7];
  int   checks;
  int   errors;
  int   exp_cnt;
  int   obs_long;
  int   obs_rpt;

  function automatic exp_t actual();
    return exp_t'({press, key_release, long_press, key_repeat, held, press_cnt});
  endfunction

  task automatic check_out(input string name, input exp_t e);
    exp_t a;
    a = actual();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got prs/rel/lng/rpt/hld=%b%b%b%b%b cnt=%0d, expected %b%b%b%b%b cnt=%0d",
               name, a.prs, a.rel, a.lng, a.rpt, a.hld, a.cnt,
               e.prs, e.rel, e.lng, e.rpt, e.hld, e.cnt);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Drive one cycle from a negedge, then compare at the next negedge.
  task automatic step(input logic k, input logic rs, input exp_t e, input string name);
    exp_t q;
    key   = k;
    reset = rs;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (long_press) obs_long++;
    if (key_repeat) obs_rpt++;
    q = sb.pop_front();
    check_out(name, q);
  endtask

  // Key high for hi cycles then low for lo cycles; offset c is the edge that samples key(c).
  task automatic run_pulse(input int hi, input int lo, input string name);
    exp_t e;
    for (int c = 0; c < hi + lo; c++) begin
      if (c == 0 && exp_cnt < 255) exp_cnt++;
      e.prs = (c == 0);
      e.rel = (lo > 0) && (c == hi);
      e.lng = (hi > LC) && (c == LC);
      e.rpt = RPT_EN && (c > LC) && (c < hi) && (((c - LC) % RC) == 0);
      e.hld = (c < hi);
      e.cnt = 8'(exp_cnt);
      step(c < hi, 1'b0, e, name);
    end
  endtask

  initial begin
    exp_t z;
    checks  = 0;
    errors  = 0;
    exp_cnt = 0;
    z       = '0;
    aclr    = 1'b0;
    reset   = 1'b0;
    key     = 1'b0;

    vt[0] = '{hi: 5,  lo: 3, n_long: 0, n_rpt_en: 0, n_rpt_dis: 0, cnt_after: 1};
    vt[1] = '{hi: 10, lo: 3, n_long: 0, n_rpt_en: 0, n_rpt_dis: 0, cnt_after: 2};
    vt[2] = '{hi: 11, lo: 3, n_long: 1, n_rpt_en: 0, n_rpt_dis: 0, cnt_after: 3};
    vt[3] = '{hi: 14, lo: 2, n_long: 1, n_rpt_en: 0, n_rpt_dis: 0, cnt_after: 4};
    vt[4] = '{hi: 15, lo: 2, n_long: 1, n_rpt_en: 1, n_rpt_dis: 0, cnt_after: 5};
    vt[5] = '{hi: 25, lo: 3, n_long: 1, n_rpt_en: 3, n_rpt_dis: 0, cnt_after: 6};
    vt[6] = '{hi: 1,  lo: 1, n_long: 0, n_rpt_en: 0, n_rpt_dis: 0, cnt_after: 7};

    repeat (3) @(negedge clk);
    check_out("aclr_state", z);
    aclr = 1'b1;
    step(1'b0, 1'b0, z, "idle_after_aclr");
    step(1'b0, 1'b0, z, "idle_after_aclr");

    for (int i = 0; i < 7; i++) begin
      obs_long = 0;
      obs_rpt  = 0;
      run_pulse(vt[i].hi, vt[i].lo, $sformatf("vec%0d_hi%0d", i, vt[i].hi));
      check_int($sformatf("vec%0d_long_count", i), obs_long, vt[i].n_long);
      check_int($sformatf("vec%0d_repeat_count", i), obs_rpt,
                RPT_EN ? vt[i].n_rpt_en : vt[i].n_rpt_dis);
      check_int($sformatf("vec%0d_press_cnt", i), int'(press_cnt), vt[i].cnt_after);
    end

    // Synchronous reset mid-HOLD: no release, then a press as key is still high.
    run_pulse(3, 0, "sync_pre_hold");
    step(1'b1, 1'b1, z, "sync_reset_hold");
    exp_cnt = 0;
    run_pulse(5, 2, "press_after_sync_reset");

    // Asynchronous clear mid-LONG.
    run_pulse(13, 0, "aclr_pre_long");
    #2 aclr = 1'b0;
    #1 check_out("aclr_async_long", z);
    @(negedge clk);
    check_out("aclr_held_low", z);
    aclr    = 1'b1;
    exp_cnt = 0;
    run_pulse(6, 2, "press_after_aclr");

    // Press counter saturation.
    for (int i = 0; i < 300; i++) begin
      run_pulse(1, 1, "saturate");
    end
    check_int("press_cnt_saturated", int'(press_cnt), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
